// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: shared types for the core-to-APB bridge.
// Provides the bridge FSM state enum, the default timeout and the peripheral window bounds.
`ifndef UART_START_ADDR
`define UART_START_ADDR 32'h1A10_0000
`endif
`ifndef DEBUG_END_ADDR
`define DEBUG_END_ADDR 32'h1A11_7FFF
`endif

package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  localparam int unsigned APB_TIMEOUT_DEFAULT = 255;

  // A limit of 0 disables the timeout but still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned lim);
    return (lim < 1) ? 1 : $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: counts ACCESS wait cycles and flags the last allowed one.
// Ports: clk, rst, en_i (wait cycle), clr_i (new access), expired_o.
import apb_bridge_pkg::*;

module apb_timeout_cnt #(
  parameter int unsigned LIMIT = APB_TIMEOUT_DEFAULT,
  parameter int unsigned W     = cnt_width(LIMIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam logic [W-1:0] LAST = W'((LIMIT == 0) ? 0 : LIMIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // cnt_q holds the wait cycles already seen, so the
  // LIMIT-th low cycle is the one where cnt_q == LIMIT-1.
  assign expired_o = (LIMIT != 0) && en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o && (LIMIT != 0)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/core2apb_master.sv
// core2apb_master: core req/gnt data port to APB3 master bridge.
// Ports: data_* core side (gnt, one-cycle rvalid response); p* APB master side.
import apb_bridge_pkg::*;

module core2apb_master #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      data_req_i,
  output logic                      data_gnt_o,
  input  logic [APB_ADDR_WIDTH-1:0] data_addr_i,
  input  logic                      data_we_i,
  input  logic [3:0]                data_be_i,
  input  logic [APB_DATA_WIDTH-1:0] data_wdata_i,
  output logic                      data_rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] data_rdata_o,
  output logic                      data_err_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic [APB_DATA_WIDTH-1:0] pwdata,
  output logic                      pwrite,
  output logic                      psel,
  output logic                      penable,
  input  logic [APB_DATA_WIDTH-1:0] prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  apb_state_e state_q, state_d;

  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      rvalid_q, rvalid_d;
  logic                      err_q, err_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic cnt_en, cnt_clr, tmo;
  logic in_win;

  // APB3 has no strobes; the full word is always forwarded.
  logic unused_be;
  assign unused_be = ^data_be_i;

  assign in_win = (data_addr_i >= `UART_START_ADDR) &&
                  (data_addr_i <= `DEBUG_END_ADDR);

  apb_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .en_i     (cnt_en),
    .clr_i    (cnt_clr),
    .expired_o(tmo)
  );

  always_comb begin
    state_d    = state_q;
    data_gnt_o = 1'b0;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pwrite_d   = pwrite_q;
    rvalid_d   = 1'b0;
    err_d      = 1'b0;
    rdata_d    = '0;
    cnt_en     = 1'b0;
    cnt_clr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        data_gnt_o = data_req_i;
        if (data_req_i) begin
          paddr_d  = data_addr_i;
          pwdata_d = data_wdata_i;
          pwrite_d = data_we_i;
          if (in_win) begin
            state_d = SETUP;
          end else begin
            rvalid_d = 1'b1;
            err_d    = 1'b1;
          end
        end
      end
      SETUP: begin
        cnt_clr = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        // pready wins over a coincident timeout.
        if (pready) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          err_d    = pslverr;
          rdata_d  = pwrite_q ? '0 : prdata;
        end else begin
          cnt_en = 1'b1;
          if (tmo) begin
            state_d  = IDLE;
            rvalid_d = 1'b1;
            err_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // psel/penable decode straight from state so reset drops them at once.
  assign psel          = (state_q != IDLE);
  assign penable       = (state_q == ACCESS);
  assign paddr         = paddr_q;
  assign pwdata        = pwdata_q;
  assign pwrite        = pwrite_q;
  assign data_rvalid_o = rvalid_q;
  assign data_err_o    = err_q;
  assign data_rdata_o  = rdata_q;

endmodule

// File: tb/tb_core2apb_master.sv
// tb_core2apb_master: directed bench for core2apb_master.
// Drives and samples on the falling edge; DUT built with a 4-cycle timeout.
module tb_core2apb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  core2apb_master #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_req_i   (req),
    .data_gnt_o   (gnt),
    .data_addr_i  (addr),
    .data_we_i    (we),
    .data_be_i    (be),
    .data_wdata_i (wdata),
    .data_rvalid_o(rvalid),
    .data_rdata_o (rdata),
    .data_err_o   (err),
    .paddr        (paddr),
    .pwdata       (pwdata),
    .pwrite       (pwrite),
    .psel         (psel),
    .penable      (penable),
    .prdata       (prdata),
    .pready       (pready),
    .pslverr      (pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 1'b0; addr = '0; we = 1'b0; be = 4'hF;
    wdata = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: zero-wait read
    req = 1'b1; addr = 32'h1A10_1000; we = 1'b0;
    #1 chk("rd_gnt", gnt, 1);
    @(negedge clk);
    req = 1'b0;
    chk("rd_setup_psel", psel, 1);
    chk("rd_setup_pen", penable, 0);
    chk("rd_paddr", paddr, 32'h1A10_1000);
    chk("rd_pwrite", pwrite, 0);
    pready = 1'b1; prdata = 32'h1234_5678;
    @(negedge clk);
    chk("rd_acc_psel", psel, 1);
    chk("rd_acc_pen", penable, 1);
    chk("rd_acc_rvalid", rvalid, 0);
    @(negedge clk);
    pready = 1'b0;
    chk("rd_rvalid", rvalid, 1);
    chk("rd_rdata", rdata, 32'h1234_5678);
    chk("rd_err", err, 0);
    chk("rd_idle_psel", psel, 0);
    @(negedge clk);
    chk("rd_pulse", rvalid, 0);

    // 2: write with 3 wait cycles, rvalid 6 cycles after grant
    req = 1'b1; addr = 32'h1A10_3004; we = 1'b1; wdata = 32'hCAFE_F00D;
    #1 chk("wr_gnt", gnt, 1);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      req = 1'b0; wdata = 32'h0;
      chk($sformatf("wr_rvalid_c%0d", i), rvalid, (i == 6) ? 1 : 0);
      if (i <= 5) begin
        chk($sformatf("wr_psel_c%0d", i), psel, 1);
        chk($sformatf("wr_pwdata_c%0d", i), pwdata, 32'hCAFE_F00D);
        chk($sformatf("wr_pwrite_c%0d", i), pwrite, 1);
      end
      if (i == 5) pready = 1'b1;
    end
    pready = 1'b0;
    chk("wr_err", err, 0);
    chk("wr_rdata", rdata, 0);

    // 3: decode error, above the window
    req = 1'b1; addr = 32'h2000_0000; we = 1'b0;
    #1 chk("dec_gnt", gnt, 1);
    @(negedge clk);
    req = 1'b0;
    chk("dec_psel", psel, 0);
    chk("dec_rvalid", rvalid, 1);
    chk("dec_err", err, 1);
    chk("dec_rdata", rdata, 0);

    // 3b: first address past the window end
    req = 1'b1; addr = 32'h1A11_8000;
    #1 chk("dec2_gnt", gnt, 1);
    @(negedge clk);
    req = 1'b0;
    chk("dec2_psel", psel, 0);
    chk("dec2_err", err, 1);
    // 3c: just below window start
    req = 1'b1; addr = 32'h1A0F_FFFC;
    @(negedge clk);
    req = 1'b0;
    chk("dec3_psel", psel, 0);
    chk("dec3_err", err, 1);

    // 4: slave error on read
    req = 1'b1; addr = 32'h1A11_0000; we = 1'b0;
    @(negedge clk);
    req = 1'b0;
    chk("se_psel", psel, 1);
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    pready = 1'b0; pslverr = 1'b0;
    chk("se_rvalid", rvalid, 1);
    chk("se_err", err, 1);
    chk("se_rdata", rdata, 32'hDEAD_BEEF);

    // 5: timeout at last window address, then back-to-back request
    req = 1'b1; addr = 32'h1A11_7FFF; we = 1'b0;
    #1 chk("to_gnt", gnt, 1);
    @(negedge clk);
    req = 1'b0;
    chk("to_setup_pen", penable, 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("to_acc%0d_psel", i), psel, 1);
      chk($sformatf("to_acc%0d_pen", i), penable, 1);
      chk($sformatf("to_acc%0d_rvalid", i), rvalid, 0);
    end
    @(negedge clk);
    chk("to_psel_drop", psel, 0);
    chk("to_pen_drop", penable, 0);
    chk("to_rvalid", rvalid, 1);
    chk("to_err", err, 1);
    chk("to_rdata", rdata, 0);
    req = 1'b1; addr = 32'h1A10_0000; we = 1'b0;
    #1 chk("b2b_gnt", gnt, 1);
    @(negedge clk);
    req = 1'b0;
    chk("b2b_psel", psel, 1);
    chk("b2b_rvalid", rvalid, 0);
    pready = 1'b1; prdata = 32'hA5A5_0F0F;
    @(negedge clk);
    @(negedge clk);
    pready = 1'b0;
    chk("b2b_rvalid2", rvalid, 1);
    chk("b2b_err", err, 0);
    chk("b2b_rdata", rdata, 32'hA5A5_0F0F);

    // 6: reset during ACCESS
    req = 1'b1; addr = 32'h1A10_2000; we = 1'b0;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("rs_acc_pen", penable, 1);
    #1 rst = 1'b1;
    #1;
    chk("rs_psel", psel, 0);
    chk("rs_pen", penable, 0);
    chk("rs_paddr", paddr, 0);
    @(negedge clk);
    rst = 1'b0;
    pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rs_norvalid%0d", i), rvalid, 0);
      chk($sformatf("rs_nopsel%0d", i), psel, 0);
    end
    pready = 1'b0;
    req = 1'b1; addr = 32'h1A10_0008; we = 1'b1; wdata = 32'h1122_3344;
    #1 chk("rs_gnt", gnt, 1);
    @(negedge clk);
    req = 1'b0;
    chk("rs_pwdata", pwdata, 32'h1122_3344);
    pready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    pready = 1'b0;
    chk("rs_rvalid", rvalid, 1);
    chk("rs_err", err, 0);
    chk("rs_rdata", rdata, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
